// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one W-bit ALU shared by two requesters with round-robin arbitration.
// Latency: request accepted at edge T, result valid after edge T+2 (IDLE -> EXEC -> RESP).
// Backpressure: the result is held on the winner's rsp port until its rsp_ready; no new request is accepted meanwhile.
//
// Ports: clk/rst (sync, active-high); req0_*/req1_* request channels (valid/ready, a, b, op);
//        rsp0_*/rsp1_* response channels (valid/ready, data); busy = FSM not in IDLE.
// Optional build macro ALU_SHARE_FLAGS_EN adds flag_zero / flag_carry outputs, registered with the result.
module alu_share_arbiter #(
  parameter int           W      = 16,
  parameter logic [W-1:0] CONST7 = W'(16'h00FF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_data,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_data,
  input  logic         rsp1_ready,
  output logic         busy
`ifdef ALU_SHARE_FLAGS_EN
  ,
  output logic         flag_zero,
  output logic         flag_carry
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           gnt;          // port id of the operation in flight
  logic           prio;         // port that wins a tie in IDLE
  logic [W-1:0]   a_r, b_r;
  logic [2:0]     op_r;
  logic [W-1:0]   data0_r, data1_r;
  logic           grant_id;
  logic           accept;
  logic           rsp_hs;
  logic [W-1:0]   alu_res;

  // Arbitration: a single valid port wins outright, a tie goes to prio.
  always_comb begin
    grant_id = (req0_valid & req1_valid) ? prio : req1_valid;
    accept   = (state == IDLE) & (req0_valid | req1_valid);
    rsp_hs   = (state == RESP) & (gnt ? rsp1_ready : rsp0_ready);
  end

  // ALU operates on the captured operands during EXEC.
  always_comb begin
    alu_res = '0;
    case (op_r)
      3'd0:    alu_res = '0;
      3'd1:    alu_res = a_r & b_r;
      3'd2:    alu_res = a_r | b_r;
      3'd3:    alu_res = a_r ^ b_r;
      3'd4:    alu_res = ~a_r;
      3'd5:    alu_res = a_r - b_r;
      3'd6:    alu_res = a_r + b_r;
      default: alu_res = CONST7;
    endcase
  end

`ifdef ALU_SHARE_FLAGS_EN
  logic [W:0] sum_ext;
  logic       carry_nxt;
  always_comb begin
    sum_ext   = {1'b0, a_r} + {1'b0, b_r};
    carry_nxt = 1'b0;
    if (op_r == 3'd6) carry_nxt = sum_ext[W];
    else if (op_r == 3'd5) carry_nxt = (a_r < b_r);
  end
`endif

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      prio    <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      data0_r <= '0;
      data1_r <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt  <= grant_id;
        a_r  <= grant_id ? req1_a  : req0_a;
        b_r  <= grant_id ? req1_b  : req0_b;
        op_r <= grant_id ? req1_op : req0_op;
      end
      // Only the winner's data register is written; the other port keeps its last result.
      if (state == EXEC) begin
        if (gnt) data1_r <= alu_res;
        else     data0_r <= alu_res;
`ifdef ALU_SHARE_FLAGS_EN
        flag_zero  <= (alu_res == '0);
        flag_carry <= carry_nxt;
`endif
      end
      // Round-robin: the port just served loses the next tie.
      if (rsp_hs) prio <= ~gnt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready = accept & ~grant_id;
    req1_ready = accept &  grant_id;
    rsp0_valid = (state == RESP) & ~gnt;
    rsp1_valid = (state == RESP) &  gnt;
    rsp0_data  = data0_r;
    rsp1_data  = data1_r;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: driver processes present queued requests,
// expected responses are queued on accept, and a monitor pops/compares on every response handshake.
module tb_alu_share_arbiter;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [1:0][W-1:0]   req_a = '0;
  logic [1:0][W-1:0]   req_b = '0;
  logic [1:0][2:0]     req_op = '0;
  logic [1:0]          rsp_valid;
  logic [1:0][W-1:0]   rsp_data;
  logic [1:0]          rsp_ready = '0;
  logic                busy;
`ifdef ALU_SHARE_FLAGS_EN
  logic                flag_zero, flag_carry;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]), .req0_ready(req_ready[0]),
    .req1_valid(req_valid[1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]), .req1_ready(req_ready[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_data(rsp_data[0]), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_data(rsp_data[1]), .rsp1_ready(rsp_ready[1]),
    .busy(busy)
`ifdef ALU_SHARE_FLAGS_EN
    , .flag_zero(flag_zero), .flag_carry(flag_carry)
`endif
  );

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; logic [W-1:0] d; logic z; logic c; } req_t;
  typedef struct { logic [W-1:0] d; logic z; logic c; } rsp_t;

  req_t pend0[$], pend1[$];
  rsp_t exp0[$], exp1[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Request drivers: accept is seen at a negedge, consumed right after the following posedge.
  initial begin : drv
    logic acc0, acc1;
    rsp_t r;
    forever begin
      @(negedge clk);
      acc0 = req_valid[0] && req_ready[0] && !rst;
      acc1 = req_valid[1] && req_ready[1] && !rst;
      @(posedge clk);
      #1;
      if (acc0) begin
        r.d = pend0[0].d; r.z = pend0[0].z; r.c = pend0[0].c;
        exp0.push_back(r);
        void'(pend0.pop_front());
        req_valid[0] = 1'b0;
      end
      if (acc1) begin
        r.d = pend1[0].d; r.z = pend1[0].z; r.c = pend1[0].c;
        exp1.push_back(r);
        void'(pend1.pop_front());
        req_valid[1] = 1'b0;
      end
      if (!req_valid[0] && pend0.size() > 0) begin
        req_a[0] = pend0[0].a; req_b[0] = pend0[0].b; req_op[0] = pend0[0].op; req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && pend1.size() > 0) begin
        req_a[1] = pend1[0].a; req_b[1] = pend1[0].b; req_op[1] = pend1[0].op; req_valid[1] = 1'b1;
      end
    end
  end

  // Response monitor
  initial begin : mon
    logic [1:0]        hold;
    logic [1:0][W-1:0] held;
    rsp_t              r;
    logic              have;
    hold = '0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = '0;
      end else begin
        check("one_rsp_valid", {31'b0, rsp_valid != 2'b11}, 32'd1);
        for (int p = 0; p < 2; p++) begin
          if (hold[p]) begin
            check("hold_valid", {31'b0, rsp_valid[p]}, 32'd1);
            check("hold_data", {16'b0, rsp_data[p]}, {16'b0, held[p]});
          end
          if (rsp_valid[p]) begin
            have = (p == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
            check(p == 0 ? "rsp0_expected" : "rsp1_expected", {31'b0, have}, 32'd1);
            if (have && rsp_ready[p]) begin
              if (p == 0) r = exp0.pop_front();
              else        r = exp1.pop_front();
              check(p == 0 ? "rsp0_data" : "rsp1_data", {16'b0, rsp_data[p]}, {16'b0, r.d});
`ifdef ALU_SHARE_FLAGS_EN
              check("flag_zero", {31'b0, flag_zero}, {31'b0, r.z});
              check("flag_carry", {31'b0, flag_carry}, {31'b0, r.c});
`endif
            end
          end
          hold[p] = rsp_valid[p] && !rsp_ready[p];
          held[p] = rsp_data[p];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [W-1:0] d, input logic z, input logic c);
    req_t q;
    q.a = a; q.b = b; q.op = op; q.d = d; q.z = z; q.c = c;
    if (p == 0) pend0.push_back(q);
    else        pend1.push_back(q);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns at the negedge where a request is first accepted; who = port id or -1 on timeout.
  task automatic wait_accept(output int who);
    who = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) begin who = 0; break; end
      if (req_valid[1] && req_ready[1]) begin who = 1; break; end
    end
    if (who < 0) begin
      fails++;
      $display("FAIL accept_timeout: no request accepted within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = pend0.size() == 0 && pend1.size() == 0 && exp0.size() == 0 && exp1.size() == 0
             && req_valid == 2'b00 && rsp_valid == 2'b00;
    end
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: pend %0d/%0d exp %0d/%0d still outstanding",
               pend0.size(), pend1.size(), exp0.size(), exp1.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int who;
    rsp_ready = 2'b11;
    tick();
    tick();
    // Reset values
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("rst_rsp0_data", {16'b0, rsp_data[0]}, 32'd0);
    check("rst_rsp1_data", {16'b0, rsp_data[1]}, 32'd0);
    tick();
    rst = 1'b0;

    // Single request on port 0, latency check
    push(0, 16'd20, 16'd10, 3'd6, 16'd30, 1'b0, 1'b0);
    wait_accept(who);
    check("single_grant", who, 32'd0);
    @(negedge clk);
    check("lat_exec_valid", {30'b0, rsp_valid}, 32'd0);
    check("lat_exec_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("lat_resp_valid", {30'b0, rsp_valid}, 32'd1);
    wait_drain();

    // Tie after reset: port 0 first, then port 1, next tie to port 0 again
    do_reset();
    push(0, 16'd20, 16'd10, 3'd5, 16'd10, 1'b0, 1'b0);
    push(1, 16'd20, 16'd10, 3'd3, 16'd30, 1'b0, 1'b0);
    wait_accept(who);
    check("tie1_grant", who, 32'd0);
    wait_drain();
    push(0, 16'd1, 16'd2, 3'd6, 16'd3, 1'b0, 1'b0);
    push(1, 16'h00F0, 16'h00FF, 3'd1, 16'h00F0, 1'b0, 1'b0);
    wait_accept(who);
    check("tie2_grant", who, 32'd0);
    wait_drain();

    // All opcodes
    push(0, 16'h00F0, 16'h0F0F, 3'd0, 16'h0000, 1'b1, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd1, 16'h0000, 1'b1, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd2, 16'h0FFF, 1'b0, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd3, 16'h0FFF, 1'b0, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd4, 16'hFF0F, 1'b0, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd5, 16'hF1E1, 1'b0, 1'b1);
    push(0, 16'h00F0, 16'h0F0F, 3'd6, 16'h0FFF, 1'b0, 1'b0);
    push(0, 16'h00F0, 16'h0F0F, 3'd7, 16'h00FF, 1'b0, 1'b0);
    wait_drain();

    // Backpressure on port 0 while port 1 waits
    do_reset();
    rsp_ready = 2'b10;
    push(0, 16'h00F0, 16'h0F0F, 3'd2, 16'h0FFF, 1'b0, 1'b0);
    push(1, 16'h1234, 16'h5678, 3'd7, 16'h00FF, 1'b0, 1'b0);
    wait_accept(who);
    check("bp_grant", who, 32'd0);
    for (int i = 0; i < 20 && !rsp_valid[0]; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp0_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("bp_busy", {31'b0, busy}, 32'd1);
      check("bp_req1_ready", {31'b0, req_ready[1]}, 32'd0);
    end
    tick();
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("bp_req1_granted", {31'b0, req_ready[1]}, 32'd1);
    wait_drain();

    // Wrap-around on port 1
    push(1, 16'hFFFF, 16'h0001, 3'd6, 16'h0000, 1'b1, 1'b1);
    push(1, 16'h0000, 16'h0001, 3'd5, 16'hFFFF, 1'b0, 1'b1);
    wait_drain();

    // Reset during EXEC aborts the operation
    push(0, 16'd5, 16'd3, 3'd6, 16'd8, 1'b0, 1'b0);
    wait_accept(who);
    check("abort_grant", who, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp0.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("abort_rsp0_data", {16'b0, rsp_data[0]}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {30'b0, rsp_valid}, 32'd0);
    end
    tick();
    push(0, 16'h0F00, 16'h00F0, 3'd2, 16'h0FF0, 1'b0, 1'b0);
    push(1, 16'h0003, 16'h0001, 3'd5, 16'h0002, 1'b0, 1'b0);
    wait_accept(who);
    check("abort_tie_grant", who, 32'd0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one W-bit ALU between two requesters (port 0, port 1) using valid/ready handshakes and round-robin arbitration.
- Captures the granted operands and opcode, computes in one registered stage, and holds the result on the winner's response port until it is accepted.
- Sits between two datapath masters and the single ALU instance, so the ALU is never duplicated.

Parameters:
W, 16, operand/result width in bits
CONST7, 16'h00FF, result for op 7 (constant load), truncated/zero-extended to W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  port 0 request valid
req0_a  input  W  port 0 operand A
req0_b  input  W  port 0 operand B
req0_op  input  3  port 0 opcode
req0_ready  output  1  port 0 request accepted this cycle
req1_valid  input  1  port 1 request valid
req1_a  input  W  port 1 operand A
req1_b  input  W  port 1 operand B
req1_op  input  3  port 1 opcode
req1_ready  output  1  port 1 request accepted this cycle
rsp0_valid  output  1  port 0 result valid
rsp0_data  output  W  port 0 result
rsp0_ready  input  1  port 0 consumer accepts result
rsp1_valid  output  1  port 1 result valid
rsp1_data  output  W  port 1 result
rsp1_ready  input  1  port 1 consumer accepts result
busy  output  1  FSM not in IDLE

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: FSM=IDLE, busy=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, priority pointer=port 0, result/operand registers=0.
- reqN_ready is combinational. It is 1 only in IDLE for the granted port, so a request is accepted on the cycle where reqN_valid & reqN_ready.
- Arbitration in IDLE:
  - Only one port valid: that port is granted.
  - Both valid: the port holding priority is granted.
  - Priority flips to the other port after each completed response handshake. The first grant after reset goes to port 0 on a tie.
- FSM states:
  - IDLE: on accept, latch a/b/op and the grant id, then go to EXEC. With no valid request, stay in IDLE.
  - EXEC: compute the result into the result register, then go to RESP (one cycle, unconditional).
  - RESP: rspG_valid=1 for the granted port G and rspG_data=result. On rspG_ready go to IDLE and flip priority; otherwise hold. Data stays stable while valid & !ready.
- Latency: accept at edge T, rsp_valid high after edge T+2. Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP).
- Input handling outside accept: requests presented while busy are ignored (ready=0). Requesters hold their valid and inputs until ready is asserted.
- The non-granted rsp port always has rsp_valid=0. Its rsp_data holds its last value.
- Opcodes, all arithmetic modulo 2^W (carry/borrow discarded):
  - 0 = 0
  - 1 = A&B
  - 2 = A|B
  - 3 = A^B
  - 4 = ~A
  - 5 = A-B
  - 6 = A+B
  - 7 = CONST7
- Same-cycle events: rspG_ready asserted in the same cycle a new request arrives. The FSM returns to IDLE first, and the new request is accepted no earlier than the following cycle.
- rst asserted in any state aborts the in-flight operation. The next cycle shows reset values, and no response is issued for the aborted request.
- rspN_ready while rspN_valid=0 is ignored.

Optional Feature:
- Macro: ALU_SHARE_FLAGS_EN.
- When defined, two extra outputs are added, flag_zero and flag_carry (1 bit each). Both are registered in EXEC alongside the result and are meaningful while either rsp_valid=1.
  - flag_zero = (result == 0).
  - flag_carry = carry-out of A+B for op 6, or borrow (A<B unsigned) for op 5, else 0.
  - Reset value of both flags is 0.
- When undefined, the ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then req0 {A=20,B=10,op=6} alone -> req0_ready=1 same cycle; rsp0_valid after 2 edges with rsp0_data=30; rsp1_valid stays 0.
- req0 {20,10,op5} and req1 {20,10,op3} valid together after reset, both rsp_ready=1 -> port 0 served first (data 10), then port 1 (data 30); the next tie goes to port 0 again.
- All ops 0..7 with A=16'h00F0, B=16'h0F0F -> results 0000, 0000, 0FFF, 0FFF, FF0F, F1E1, 0FFF, 00FF.
- Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and data held stable, busy=1, req1_ready=0 throughout; accepted on ready, then req1 granted the next IDLE cycle.
- Wrap-around: A=16'hFFFF, B=1, op6 -> data 0000; A=0, B=1, op5 -> data FFFF. With ALU_SHARE_FLAGS_EN these give zero=1/carry=1 and zero=0/carry=1 respectively.
- Reset asserted in EXEC -> next cycle busy=0, rsp valids 0, no response emitted; a subsequent tie is granted to port 0.
